// File: rtl/bram_arb_pkg.sv
// Shared types and helpers for the BRAM port arbiter.
package bram_arb_pkg;

    localparam int unsigned WE_WIDTH = 4;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/bram_arb_rdtrack.sv
// Read-return tracker: RD_LATENCY-deep {valid,id} pipeline decoded into per-requester rvalid.
module bram_arb_rdtrack
    import bram_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned IDW        = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_issue,
    input  logic [IDW-1:0]     i_id,
    output logic [NUM_REQ-1:0] o_rvalid
);

    logic [RD_LATENCY-1:0] r_vld;
    logic [IDW-1:0]        r_id [RD_LATENCY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
            for (int unsigned i = 0; i < RD_LATENCY; i++) begin
                r_id[i] <= '0;
            end
        end else begin
            r_vld[0] <= i_issue;
            r_id[0]  <= i_id;
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_id[i]  <= r_id[i-1];
            end
        end
    end

    always_comb begin
        o_rvalid = '0;
        if (r_vld[RD_LATENCY-1]) begin
            o_rvalid[r_id[RD_LATENCY-1]] = 1'b1;
        end
    end

endmodule

// File: rtl/bram_arbiter.sv
// Round-robin arbiter sharing one BRAM port among NUM_REQ requesters, with burst lock.
// Optional statistics counters are enabled by defining BRAM_ARB_STATS_EN.
module bram_arbiter
    import bram_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned MAX_LOCK   = 16
) (
    input  logic                           aclk,
    input  logic                           areset,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ-1:0]             req_lock,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wrdata,
    input  logic [NUM_REQ*WE_WIDTH-1:0]    req_we,
    output logic [NUM_REQ-1:0]             gnt,
    output logic [NUM_REQ-1:0]             rvalid,
    output logic [DATA_WIDTH-1:0]          rddata,
    output logic [ADDR_WIDTH-1:0]          BRAM_ADDR,
    output logic [DATA_WIDTH-1:0]          BRAM_WRDATA,
    output logic [WE_WIDTH-1:0]            BRAM_WE,
    output logic                           BRAM_EN,
    output logic                           BRAM_CLK,
    input  logic [DATA_WIDTH-1:0]          BRAM_RDDATA
`ifdef BRAM_ARB_STATS_EN
    ,
    output logic [NUM_REQ*32-1:0]          stat_grants,
    output logic [NUM_REQ*32-1:0]          stat_stall
`endif
);

    localparam int unsigned     IDW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned     CW       = $clog2(MAX_LOCK + 1);
    localparam logic [CW-1:0]   LOCK_MAX = CW'(MAX_LOCK);

    arb_state_t      r_state, w_state_nxt;
    logic [IDW-1:0]  r_rr, w_rr_nxt;
    logic [IDW-1:0]  r_owner, w_owner_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic [ADDR_WIDTH-1:0] r_addr_hold;

    logic                  w_win, w_grant, w_own_ok, w_others, w_issue;
    logic [IDW-1:0]        w_win_id, w_scan_id;
    logic [NUM_REQ-1:0]    w_mask, w_owner_oh;
    logic [ADDR_WIDTH-1:0] w_win_addr;
    logic [WE_WIDTH-1:0]   w_win_we;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state     <= ARB_IDLE;
            r_rr        <= '0;
            r_owner     <= '0;
            r_cnt       <= '0;
            r_addr_hold <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rr    <= w_rr_nxt;
            r_owner <= w_owner_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_grant) begin
                r_addr_hold <= w_win_addr;
            end
        end
    end

    // In LOCKED, r_rr already equals owner+1, so a fallback scan from r_rr
    // with the owner masked out is the "round-robin from owner+1" rule.
    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr;
        w_owner_nxt = r_owner;
        w_cnt_nxt   = r_cnt;
        w_win       = 1'b0;
        w_win_id    = '0;
        w_scan_id   = '0;
        w_owner_oh  = '0;
        w_owner_oh[r_owner] = 1'b1;
        w_others    = |(req & ~w_owner_oh);
        w_own_ok    = (r_state == ARB_LOCKED) && req[r_owner]
                      && !((r_cnt >= LOCK_MAX) && w_others);
        w_mask      = (r_state == ARB_LOCKED) ? (req & ~w_owner_oh) : req;

        if (w_own_ok) begin
            w_win    = 1'b1;
            w_win_id = r_owner;
            w_rr_nxt = IDW'(rr_next(32'(r_owner), NUM_REQ));
            if (req_lock[r_owner]) begin
                if (r_cnt < LOCK_MAX) begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end else begin
                w_state_nxt = ARB_IDLE;
                w_cnt_nxt   = '0;
            end
        end else begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                w_scan_id = IDW'((32'(r_rr) + k) % NUM_REQ);
                if (!w_win && w_mask[w_scan_id]) begin
                    w_win    = 1'b1;
                    w_win_id = w_scan_id;
                end
            end
            w_state_nxt = ARB_IDLE;
            w_cnt_nxt   = '0;
            if (w_win) begin
                w_rr_nxt = IDW'(rr_next(32'(w_win_id), NUM_REQ));
                if (req_lock[w_win_id]) begin
                    w_state_nxt = ARB_LOCKED;
                    w_owner_nxt = w_win_id;
                    w_cnt_nxt   = CW'(1);
                end
            end
        end
    end

    assign w_grant    = w_win & ~areset;
    assign w_win_addr = req_addr[32'(w_win_id)*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_win_we   = req_we[32'(w_win_id)*WE_WIDTH +: WE_WIDTH];
    assign w_issue    = w_grant && (w_win_we == '0);

    always_comb begin
        gnt = '0;
        if (w_grant) begin
            gnt[w_win_id] = 1'b1;
        end
    end

    assign BRAM_ADDR   = w_grant ? w_win_addr : r_addr_hold;
    assign BRAM_WRDATA = req_wrdata[32'(w_win_id)*DATA_WIDTH +: DATA_WIDTH];
    assign BRAM_WE     = w_grant ? w_win_we : '0;
    assign BRAM_EN     = w_grant;
    assign BRAM_CLK    = aclk;
    assign rddata      = BRAM_RDDATA;

    bram_arb_rdtrack #(
        .NUM_REQ   (NUM_REQ),
        .RD_LATENCY(RD_LATENCY),
        .IDW       (IDW)
    ) u_rdtrack (
        .clk     (aclk),
        .rst     (areset),
        .i_issue (w_issue),
        .i_id    (w_win_id),
        .o_rvalid(rvalid)
    );

`ifdef BRAM_ARB_STATS_EN
    logic [31:0] r_stat_g [NUM_REQ];
    logic [31:0] r_stat_s [NUM_REQ];

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                r_stat_g[i] <= '0;
                r_stat_s[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (gnt[i] && (r_stat_g[i] != '1)) begin
                    r_stat_g[i] <= r_stat_g[i] + 32'd1;
                end
                if (req[i] && !gnt[i] && (r_stat_s[i] != '1)) begin
                    r_stat_s[i] <= r_stat_s[i] + 32'd1;
                end
            end
        end
    end

    always_comb begin
        stat_grants = '0;
        stat_stall  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            stat_grants[i*32 +: 32] = r_stat_g[i];
            stat_stall[i*32 +: 32]  = r_stat_s[i];
        end
    end
`endif

endmodule

// File: doc/bram_arbiter.md
Name: bram_arbiter

Overview:
- Shares one BRAM port (ADDR/WRDATA/WE/EN/CLK/RDDATA) among NUM_REQ requesters, e.g. several pe_con instances or a pe_con plus host loader.
- Round-robin arbitration, one access per cycle.
- Optional burst lock with a starvation bound.
- Routes read data back to the issuing requester after the fixed BRAM read latency.
- Sits between the pe_con controllers and my_bram.

Parameters:
- NUM_REQ, 2: number of requesters, 2..4.
- ADDR_WIDTH, 32: BRAM address width.
- DATA_WIDTH, 32: BRAM data width.
- RD_LATENCY, 2: cycles from accepted read to BRAM_RDDATA valid, 1..4.
- MAX_LOCK, 16: maximum consecutive locked grants before lock is overridden when others wait.

Ports:
- aclk  in  1  clock; forwarded as BRAM_CLK.
- areset  in  1  asynchronous active-high reset.
- req  in  NUM_REQ  request per requester.
- req_lock  in  NUM_REQ  hold grant for next cycle (burst).
- req_addr  in  NUM_REQ*ADDR_WIDTH  flattened address, requester i at slice i.
- req_wrdata  in  NUM_REQ*DATA_WIDTH  flattened write data.
- req_we  in  NUM_REQ*4  byte write enables; nonzero means write, zero means read.
- gnt  out  NUM_REQ  one-hot, access accepted this cycle.
- rvalid  out  NUM_REQ  read data valid for requester i.
- rddata  out  DATA_WIDTH  read data, shared bus, qualified by rvalid.
- BRAM_ADDR  out  ADDR_WIDTH  to BRAM.
- BRAM_WRDATA  out  DATA_WIDTH  to BRAM.
- BRAM_WE  out  4  to BRAM.
- BRAM_EN  out  1  high in any granted cycle.
- BRAM_CLK  out  1  equals aclk.
- BRAM_RDDATA  in  DATA_WIDTH  from BRAM.

Behaviour:
- Reset (async, areset=1):
  - Outputs: gnt=0, rvalid=0, BRAM_WE=0, BRAM_EN=0.
  - State: rr pointer=0, lock owner cleared, lock counter=0, read-tracking pipeline flushed.
  - Reads in flight at reset are dropped; no rvalid is ever issued for them.
- Handshake:
  - Requester holds req, addr, wrdata and we stable until it sees gnt.
  - gnt is combinational from req and registered state; the access happens in the gnt cycle.
  - Requester may drop or change the request the cycle after gnt.
- Arbitration states: IDLE and LOCKED.
  - IDLE: winner is the first requesting index at or after rr, wrapping modulo NUM_REQ. After the grant, rr = winner+1 mod NUM_REQ. If winner has req_lock=1, go to LOCKED with owner=winner and count=1.
  - LOCKED: owner wins whenever it requests. count increments per owner grant.
  - Return to IDLE when any of:
    - owner drops req_lock;
    - owner drops req, and others are then arbitrated in the same cycle;
    - count reaches MAX_LOCK while another req is pending. The owner is not granted that cycle, and round-robin from owner+1 applies.
- Datapath mux:
  - BRAM_ADDR/WRDATA/WE are driven from the winner.
  - With no winner: BRAM_WE=0, BRAM_EN=0, BRAM_ADDR holds the last value.
- Read return:
  - Shift register of RD_LATENCY entries holding {valid, id}.
  - Entry written on a granted read (we==0).
  - rvalid[id] pulses exactly RD_LATENCY cycles after gnt; rddata = BRAM_RDDATA in that cycle.
  - Writes produce no rvalid.
  - Back-to-back reads from mixed requesters return in issue order, one per cycle.
- Read-after-write to the same address on consecutive cycles returns the new data (BRAM write-first is assumed for the write in cycle t and read in cycle t+1).
- Single requester: granted every cycle it requests, zero bubbles.

Optional Feature:
- Macro BRAM_ARB_STATS_EN.
- When defined:
  - Adds output stat_grants (NUM_REQ*32), per-requester saturating grant counters.
  - Adds output stat_stall (NUM_REQ*32), cycles with req=1 and gnt=0.
  - Both cleared by areset; saturate at 32'hFFFFFFFF.
- When undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Package bram_arb_pkg:
  - WE_WIDTH=4.
  - Function for round-robin next-index.
  - State encoding constants ARB_IDLE, ARB_LOCKED.
- Sub-module bram_arb_rdtrack: the RD_LATENCY {valid,id} pipeline plus rvalid decode.

Test Plan:
- Reset mid-read: grant read to req0 at addr 0x10, assert areset next cycle → rvalid stays 0 through 5 cycles after release; gnt=0 and BRAM_EN=0 during reset.
- Contention: req0 and req1 both read continuously, rr=0 after reset → gnt sequence 01,10,01,10…; rvalid alternates, each rvalid arriving 2 cycles after its gnt with the matching BRAM word.
- Burst lock: req0 with lock and 8 writes while req1 requests → req0 gets 8 consecutive grants, then req1 is granted on cycle 9.
- Starvation bound: req0 locks for 40 cycles, MAX_LOCK=16, req1 pending → req1 granted on cycle 17; req0 resumes afterwards.
- Write then read: req1 writes 0xDEADBEEF to 0x20 with we=4'hF, then reads 0x20 → rvalid[1] with rddata=0xDEADBEEF; no rvalid for the write.
- Stats (BRAM_ARB_STATS_EN): in the contention scenario, after 10 grant cycles → stat_grants = 5/5; stat_stall increments every cycle a requester waits.
